// File: rtl/tpu_pkg.sv
// Shared control-unit / memory-sequencer definitions: opcodes, sequencer states
// and default datapath dimensions.
package tpu_pkg;

  localparam int TPU_N      = 2;
  localparam int TPU_DATA_W = 8;
  localparam int TPU_WORD_W = 16;
  localparam int TPU_ADDR_W = 13;

  typedef enum logic [1:0] {
    CMD_WEIGHT,
    CMD_INPUT,
    CMD_STORE,
    CMD_EXT
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_DRAIN,
    ST_WR,
    ST_EXT_RD,
    ST_EXT_WAIT,
    ST_EXT_SEND
  } state_t;

  // Entry state of the transaction that serves a given opcode.
  function automatic state_t first_state(input opcode_t op);
    case (op)
      CMD_WEIGHT, CMD_INPUT: return ST_RD;
      CMD_STORE:             return ST_WR;
      default:               return ST_EXT_RD;
    endcase
  endfunction

endpackage

// File: rtl/tpu_mem_sequencer_if.sv
// Unified-buffer port plus the off-chip valid/ready read stream of the sequencer.
interface tpu_mem_sequencer_if import tpu_pkg::*; #(
  parameter int ADDR_W = TPU_ADDR_W,
  parameter int WORD_W = TPU_WORD_W
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_wr_en;
  logic [WORD_W-1:0] mem_wdata;

  logic [WORD_W-1:0] ext_data;
  logic              ext_valid;
  logic              ext_ready;
  logic              ext_last;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata,
    output ext_data, ext_valid, ext_last,
    input  ext_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata,
    input  ext_data, ext_valid, ext_last,
    output ext_ready
  );

endinterface

// File: rtl/tpu_cmd_edge_queue.sv
// Turns the level command strobes into single-shot commands, arbitrates
// simultaneous fires and holds one command while the sequencer is busy.
module tpu_cmd_edge_queue import tpu_pkg::*; #(
  parameter int ADDR_W = TPU_ADDR_W,
  parameter int RES_W  = TPU_N * TPU_N * TPU_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_weight,
  input  logic              load_input,
  input  logic              store,
  input  logic              ext,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [RES_W-1:0]  result_in,
  input  logic              take_new,
  input  logic              take_pend,
  output logic              new_valid,
  output opcode_t           new_op,
  output logic              pend_valid,
  output opcode_t           pend_op,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [RES_W-1:0]  pend_data,
  output logic              overrun
);

  logic [3:0] strobes;
  logic [3:0] strobe_q;
  logic [3:0] rise;
  logic       multi_fire;
  logic       to_slot;

  assign strobes    = {ext, store, load_input, load_weight};
  assign rise       = strobes & ~strobe_q;
  assign multi_fire = (rise & (rise - 4'd1)) != 4'd0;
  assign to_slot    = new_valid && !take_new;

  // NOTE: every output gets a value before the if-chain so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    new_valid = |rise;
    new_op    = CMD_WEIGHT;
    if      (rise[0]) new_op = CMD_WEIGHT;
    else if (rise[1]) new_op = CMD_INPUT;
    else if (rise[2]) new_op = CMD_STORE;
    else if (rise[3]) new_op = CMD_EXT;
  end

  // NOTE: state is updated with <= so every flop samples the pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q   <= '0;
      pend_valid <= 1'b0;
      pend_op    <= CMD_WEIGHT;
      pend_addr  <= '0;
      pend_data  <= '0;
      overrun    <= 1'b0;
    end else begin
      strobe_q <= strobes;
      if (to_slot && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_op    <= new_op;
        pend_addr  <= base_address;
        pend_data  <= result_in;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end
      // Losing simultaneous fires and fires into a full slot are lost.
      if (multi_fire || (to_slot && pend_valid)) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/tpu_mem_sequencer.sv
// Runs unified-buffer transactions for decoded control-unit commands: array
// weight/input loads, result stores and off-chip streaming reads.
module tpu_mem_sequencer import tpu_pkg::*; #(
  parameter int N      = TPU_N,
  parameter int DATA_W = TPU_DATA_W,
  parameter int WORD_W = TPU_WORD_W,
  parameter int ADDR_W = TPU_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        base_address,
  input  logic                     load_weight,
  input  logic                     load_input,
  input  logic                     store,
  input  logic                     ext,
  input  logic [N*N*WORD_W-1:0]    result_in,
  tpu_mem_sequencer_if.master      bus,
  output logic [N*N*DATA_W-1:0]    weight_flat,
  output logic [N*N*DATA_W-1:0]    input_flat,
  output logic                     weights_ready,
  output logic                     inputs_ready,
  output logic                     busy,
  output logic                     overrun
);

  localparam int NW    = N * N;
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NW - 1);

  state_t                state, state_nxt;
  opcode_t               op;
  logic [CNT_W-1:0]      k;
  logic [ADDR_W-1:0]     base;
  logic [NW*WORD_W-1:0]  snap;
  logic                  cap_valid;
  logic [CNT_W-1:0]      cap_k;
  logic [WORD_W-1:0]     ext_data_q;
  logic                  ext_last_q;

  logic                  new_valid, pend_valid;
  opcode_t               new_op, pend_op;
  logic [ADDR_W-1:0]     pend_addr;
  logic [NW*WORD_W-1:0]  pend_data;

  logic                  done, take_new, take_pend, start;
  opcode_t               start_op;
  logic [ADDR_W-1:0]     start_addr;
  logic [NW*WORD_W-1:0]  start_data;
  logic                  rd_phase, wr_phase;

  tpu_cmd_edge_queue #(.ADDR_W(ADDR_W), .RES_W(NW*WORD_W)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .load_weight  (load_weight),
    .load_input   (load_input),
    .store        (store),
    .ext          (ext),
    .base_address (base_address),
    .result_in    (result_in),
    .take_new     (take_new),
    .take_pend    (take_pend),
    .new_valid    (new_valid),
    .new_op       (new_op),
    .pend_valid   (pend_valid),
    .pend_op      (pend_op),
    .pend_addr    (pend_addr),
    .pend_data    (pend_data),
    .overrun      (overrun)
  );

  // A pending command always goes before a fresh fire, and only a fully idle
  // FSM accepts a fresh fire directly.
  always_comb begin
    case (state)
      ST_RD_DRAIN: done = 1'b1;
      ST_WR:       done = (k == LAST);
      ST_EXT_SEND: done = bus.ext_ready && (k == LAST);
      default:     done = 1'b0;
    endcase
    take_pend  = pend_valid && ((state == ST_IDLE) || done);
    take_new   = new_valid && (state == ST_IDLE) && !pend_valid;
    start      = take_pend || take_new;
    start_op   = take_pend ? pend_op   : new_op;
    start_addr = take_pend ? pend_addr : base_address;
    start_data = take_pend ? pend_data : result_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = first_state(start_op);
      ST_RD:       if (k == LAST) state_nxt = ST_RD_DRAIN;
      ST_RD_DRAIN: state_nxt = start ? first_state(start_op) : ST_IDLE;
      ST_WR:       if (done) state_nxt = start ? first_state(start_op) : ST_IDLE;
      ST_EXT_RD:   state_nxt = ST_EXT_WAIT;
      ST_EXT_WAIT: state_nxt = ST_EXT_SEND;
      ST_EXT_SEND: begin
        if (bus.ext_ready)
          state_nxt = done ? (start ? first_state(start_op) : ST_IDLE) : ST_EXT_RD;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op            <= CMD_WEIGHT;
      k             <= '0;
      base          <= '0;
      snap          <= '0;
      cap_valid     <= 1'b0;
      cap_k         <= '0;
      weight_flat   <= '0;
      input_flat    <= '0;
      weights_ready <= 1'b0;
      inputs_ready  <= 1'b0;
      ext_data_q    <= '0;
      ext_last_q    <= 1'b0;
    end else begin
      // Read data lags its address by one cycle, so capture trails issue.
      cap_valid <= (state == ST_RD);
      cap_k     <= k;
      if (cap_valid) begin
        if (op == CMD_WEIGHT) weight_flat[cap_k*DATA_W +: DATA_W] <= bus.mem_rdata[DATA_W-1:0];
        else                  input_flat[cap_k*DATA_W +: DATA_W]  <= bus.mem_rdata[DATA_W-1:0];
      end
      if (state == ST_RD_DRAIN) begin
        if (op == CMD_WEIGHT) weights_ready <= 1'b1;
        else                  inputs_ready  <= 1'b1;
      end

      case (state)
        ST_RD, ST_WR: k <= (k == LAST) ? '0 : k + 1'b1;
        ST_EXT_WAIT: begin
          ext_data_q <= bus.mem_rdata;
          ext_last_q <= (k == LAST);
        end
        ST_EXT_SEND: if (bus.ext_ready) k <= (k == LAST) ? '0 : k + 1'b1;
        default: ;
      endcase

      if (start) begin
        op   <= start_op;
        base <= start_addr;
        k    <= '0;
        if (start_op == CMD_STORE)  snap          <= start_data;
        if (start_op == CMD_WEIGHT) weights_ready <= 1'b0;
        if (start_op == CMD_INPUT)  inputs_ready  <= 1'b0;
      end
    end
  end

  // Bus strobes decode straight from the state register, so a reset drops
  // them without waiting for a clock edge.
  assign rd_phase      = (state == ST_RD) || (state == ST_EXT_RD);
  assign wr_phase      = (state == ST_WR);
  assign bus.mem_rd_en = rd_phase;
  assign bus.mem_wr_en = wr_phase;
  assign bus.mem_addr  = (rd_phase || wr_phase) ? base + ADDR_W'(k) : '0;
  assign bus.mem_wdata = wr_phase ? snap[k*WORD_W +: WORD_W] : '0;
  assign bus.ext_valid = (state == ST_EXT_SEND);
  assign bus.ext_data  = ext_data_q;
  assign bus.ext_last  = (state == ST_EXT_SEND) && ext_last_q;
  assign busy          = (state != ST_IDLE) || pend_valid;

endmodule

// File: tb/tb_tpu_mem_sequencer.sv
// Self-checking bench: directed scenarios plus randomized single commands,
// compared against a word-level model of memory and the expected transfers.
module tb_tpu_mem_sequencer;
  import tpu_pkg::*;

  localparam int N = 2, DATA_W = 8, WORD_W = 16, ADDR_W = 13, NW = N * N;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0]     base_address;
  logic                  load_weight, load_input, store, ext;
  logic [NW*WORD_W-1:0]  result_in;
  logic [NW*DATA_W-1:0]  weight_flat, input_flat;
  logic                  weights_ready, inputs_ready, busy, overrun;

  tpu_mem_sequencer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  tpu_mem_sequencer #(.N(N), .DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .base_address  (base_address),
    .load_weight   (load_weight),
    .load_input    (load_input),
    .store         (store),
    .ext           (ext),
    .result_in     (result_in),
    .bus           (bus),
    .weight_flat   (weight_flat),
    .input_flat    (input_flat),
    .weights_ready (weights_ready),
    .inputs_ready  (inputs_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  // Unified buffer with a one-cycle read latency and a bench preload port.
  logic [WORD_W-1:0] mem     [0:MEM_SZ-1];
  logic [WORD_W-1:0] ref_mem [0:MEM_SZ-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr;
  logic [WORD_W-1:0] pl_data;

  logic [ADDR_W-1:0]        rd_log [$];
  logic [ADDR_W+WORD_W-1:0] wr_log [$];
  logic [WORD_W:0]          ext_log[$];
  int                       both_hi = 0, stall_viol = 0;
  logic                     stalled = 1'b0;
  logic [WORD_W-1:0]        stall_data = '0;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_en)    mem[pl_addr] <= pl_data;
    if (bus.mem_rd_en) rd_log.push_back(bus.mem_addr);
    if (bus.mem_wr_en) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.ext_valid && bus.ext_ready) ext_log.push_back({bus.ext_last, bus.ext_data});
    if (bus.mem_rd_en && bus.mem_wr_en) both_hi <= both_hi + 1;
    if (stalled && (!bus.ext_valid || bus.ext_data != stall_data)) stall_viol <= stall_viol + 1;
    stalled    <= bus.ext_valid && !bus.ext_ready;
    stall_data <= bus.ext_data;
  end

  int n_checks = 0, n_errors = 0;
  int ready_mode = 0, stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_strobe(input int op, input logic v);
    case (op)
      0:       load_weight = v;
      1:       load_input  = v;
      2:       store       = v;
      default: ext         = v;
    endcase
  endtask

  // Consumer: always ready, random, or three stall cycles per offered word.
  task automatic drive_ready();
    case (ready_mode)
      0: bus.ext_ready = 1'b1;
      1: bus.ext_ready = ($urandom % 2) == 1;
      default: begin
        if (bus.ext_valid && stall_cnt < 3) begin
          bus.ext_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.ext_ready = bus.ext_valid;
          stall_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic run_cmd(input int op, input logic [ADDR_W-1:0] base, input int hold, output int lat);
    int cycles = 0;
    rd_log.delete(); wr_log.delete(); ext_log.delete();
    lat = -1; stall_cnt = 0;
    base_address = base;
    set_strobe(op, 1'b1);
    drive_ready();
    while (cycles < 400) begin
      tick();
      cycles++;
      if (op == 0 && weights_ready && lat < 0) lat = cycles;
      if (op == 1 && inputs_ready && lat < 0) lat = cycles;
      if (cycles == hold) set_strobe(op, 1'b0);
      if (cycles == 1) result_in = {$urandom, $urandom};
      drive_ready();
      if (cycles >= hold && !busy) break;
    end
    set_strobe(op, 1'b0);
    check("cmd_completes", 64'(cycles < 400), 64'd1);
  endtask

  task automatic verify(input int op, input logic [ADDR_W-1:0] base,
                        input logic [NW*WORD_W-1:0] snap, input int lat,
                        input logic [NW*DATA_W-1:0] other_before);
    logic [ADDR_W-1:0]    a;
    logic [NW*DATA_W-1:0] exp_flat;
    exp_flat = '0;
    if (op != 2) begin
      check("rd_count", 64'(rd_log.size()), 64'(NW));
      for (int i = 0; i < NW; i++) begin
        a = base + ADDR_W'(i);
        check("rd_addr", (i < rd_log.size()) ? 64'(rd_log[i]) : '1, 64'(a));
        exp_flat[i*DATA_W +: DATA_W] = ref_mem[a][DATA_W-1:0];
      end
    end
    case (op)
      0, 1: begin
        check("load_flat", (op == 0) ? 64'(weight_flat) : 64'(input_flat), 64'(exp_flat));
        check("other_flat", (op == 0) ? 64'(input_flat) : 64'(weight_flat), 64'(other_before));
        check("ready_latency", 64'(lat), 64'(NW + 2));
        check("load_no_write", 64'(wr_log.size()), 64'd0);
      end
      2: begin
        check("wr_count", 64'(wr_log.size()), 64'(NW));
        for (int i = 0; i < NW; i++) begin
          a = base + ADDR_W'(i);
          check("wr_word", (i < wr_log.size()) ? 64'(wr_log[i]) : '1,
                64'({a, snap[i*WORD_W +: WORD_W]}));
          ref_mem[a] = snap[i*WORD_W +: WORD_W];
        end
      end
      default: begin
        check("ext_count", 64'(ext_log.size()), 64'(NW));
        for (int i = 0; i < NW; i++) begin
          a = base + ADDR_W'(i);
          check("ext_word", (i < ext_log.size()) ? 64'(ext_log[i]) : '1,
                64'({(i == NW - 1), ref_mem[a]}));
        end
      end
    endcase
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
    check({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_flats"}, {weight_flat, input_flat}, 64'd0);
    check({tag, "_flags"}, 64'({weights_ready, inputs_ready, busy, overrun, bus.ext_valid, bus.ext_last}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int lat, op, hold;
    logic [ADDR_W-1:0]    b;
    logic [NW*WORD_W-1:0] snap;
    logic [NW*DATA_W-1:0] other;

    reset = 1'b1; base_address = '0; result_in = '0;
    load_weight = 1'b0; load_input = 1'b0; store = 1'b0; ext = 1'b0;
    bus.ext_ready = 1'b0;
    tick(); tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Weight load with a two-cycle strobe.
    preload(13'd100, 16'h0011); preload(13'd101, 16'h0022);
    preload(13'd102, 16'h0033); preload(13'd103, 16'h0044);
    other = input_flat;
    run_cmd(0, 13'd100, 2, lat);
    verify(0, 13'd100, '0, lat, other);
    check("weight_value", 64'(weight_flat), 64'h44332211);

    // Store held for twenty cycles fires once; snapshot survives result_in change.
    snap = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    result_in = snap;
    run_cmd(2, 13'd200, 20, lat);
    verify(2, 13'd200, snap, lat, '0);

    // Off-chip read with three stall cycles per word.
    for (int i = 0; i < NW; i++) preload(13'd8 + ADDR_W'(i), 16'h00A0 + 16'(i));
    ready_mode = 2;
    run_cmd(3, 13'd8, 1, lat);
    verify(3, 13'd8, '0, lat, '0);
    ready_mode = 0;
    check("no_overrun_yet", 64'(overrun), 64'd0);

    // Weight, then input two cycles later (queued), then a store that is dropped.
    for (int i = 0; i < NW; i++) begin
      preload(13'd300 + ADDR_W'(i), 16'($urandom));
      preload(13'd400 + ADDR_W'(i), 16'($urandom));
    end
    rd_log.delete(); wr_log.delete();
    base_address = 13'd300; load_weight = 1'b1;
    tick(); tick();
    load_weight = 1'b0; base_address = 13'd400; load_input = 1'b1;
    tick();
    load_input = 1'b0; base_address = 13'd500; store = 1'b1;
    check("queued_busy", 64'(busy), 64'd1);
    tick();
    store = 1'b0;
    for (int c = 0; c < 60 && busy; c++) tick();
    check("b2b_idle", 64'(busy), 64'd0);
    check("b2b_rd_count", 64'(rd_log.size()), 64'(2 * NW));
    for (int i = 0; i < NW; i++) begin
      check("b2b_rd_w", (i < rd_log.size()) ? 64'(rd_log[i]) : '1, 64'(300 + i));
      check("b2b_rd_i", (NW + i < rd_log.size()) ? 64'(rd_log[NW + i]) : '1, 64'(400 + i));
      check("b2b_wflat", 64'(weight_flat[i*DATA_W +: DATA_W]), 64'(ref_mem[300 + i][DATA_W-1:0]));
      check("b2b_iflat", 64'(input_flat[i*DATA_W +: DATA_W]), 64'(ref_mem[400 + i][DATA_W-1:0]));
    end
    check("b2b_ready", 64'({weights_ready, inputs_ready}), 64'b11);
    check("b2b_store_dropped", 64'(wr_log.size()), 64'd0);
    check("b2b_overrun", 64'(overrun), 64'd1);

    // Input load across the top of the address space.
    for (int i = 0; i < NW; i++) preload(13'd8190 + ADDR_W'(i), 16'($urandom));
    other = weight_flat;
    run_cmd(1, 13'd8190, 1, lat);
    verify(1, 13'd8190, '0, lat, other);

    // Reset in the middle of a store, at its third word.
    result_in = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    base_address = 13'd600; store = 1'b1;
    tick(); tick(); tick();
    check("mid_store_wr", 64'(bus.mem_wr_en), 64'd1);
    check("mid_store_addr", 64'(bus.mem_addr), 64'd602);
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    store = 1'b0;
    ref_mem[600] = 16'h0A0A; ref_mem[601] = 16'h0B0B;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < NW; i++) preload(13'd700 + ADDR_W'(i), 16'($urandom));
    run_cmd(0, 13'd700, 3, lat);
    verify(0, 13'd700, '0, lat, '0);

    // Randomized single commands, including near-wrap bases and random backpressure.
    for (int it = 0; it < 20; it++) begin
      op   = int'($urandom % 4);
      b    = ($urandom % 4 == 0) ? ADDR_W'(MEM_SZ - $urandom_range(1, 3)) : ADDR_W'($urandom);
      hold = $urandom_range(1, 25);
      ready_mode = int'($urandom % 3);
      snap = {$urandom, $urandom};
      result_in = snap;
      if (op != 2) for (int i = 0; i < NW; i++) preload(b + ADDR_W'(i), 16'($urandom));
      other = (op == 0) ? input_flat : weight_flat;
      run_cmd(op, b, hold, lat);
      verify(op, b, snap, lat, other);
    end
    ready_mode = 0;

    // Read back stored data through the off-chip port.
    result_in = {16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678};
    snap = result_in;
    run_cmd(2, 13'd8191, 1, lat);
    verify(2, 13'd8191, snap, lat, '0);
    run_cmd(3, 13'd8191, 1, lat);
    verify(3, 13'd8191, '0, lat, '0);

    tick();
    check("rd_wr_exclusive", 64'(both_hi), 64'd0);
    check("ext_stable_under_stall", 64'(stall_viol), 64'd0);
    check("overrun_after_reset", 64'(overrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
